// File: rtl/alu_mdu_seq.sv
// Multi-cycle EX unit: RV32I ALU (1 cycle) plus RV32M shift-add multiplier and restoring divider.
// Build option ALU_MDU_DIV_EN includes the divider; without it divide ops return 0 in one cycle.
module alu_mdu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam int               CNT_W     = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;
  logic   accept, needs_iter;

  function automatic logic [3:0] m_flags(input logic [XLEN-1:0] r);
    return {2'b00, r[XLEN-1], (r == '0)};
  endfunction

  // ---------------- base ALU ----------------
  logic                   is_m, sub;
  logic [XLEN-1:0]        b_add, sum, alu_res;
  logic signed [XLEN-1:0] sra_res;
  logic                   carry, flag_v, flag_n, flag_z;
  logic [SHAMT_W-1:0]     shamt;

  assign is_m         = (funct7 == 7'b0000001);
  assign sub          = funct7[5] | (funct3 == 3'b010) | (funct3 == 3'b011);
  assign b_add        = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_add} + {{XLEN{1'b0}}, sub};
  assign flag_n       = sum[XLEN-1];
  assign flag_z       = (sum == '0);
  assign flag_v       = (a[XLEN-1] ^ sum[XLEN-1]) & ~(a[XLEN-1] ^ b[XLEN-1] ^ sub);
  assign shamt        = b[SHAMT_W-1:0];
  // Kept as its own signed net so the arithmetic shift is not demoted to logical.
  assign sra_res      = $signed(a) >>> shamt;

  always_comb begin
    case (funct3)
      3'b000:  alu_res = sum;
      3'b001:  alu_res = a << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, flag_n ^ flag_v};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, ~carry};
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = funct7[5] ? sra_res : (a >> shamt);
      3'b110:  alu_res = a | b;
      default: alu_res = a & b;
    endcase
  end

  // ---------------- M-op operand preparation ----------------
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg = a_sgn & a[XLEN-1];
  assign b_neg = b_sgn & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

`ifdef ALU_MDU_DIV_EN
  logic            div_quick;
  logic [XLEN-1:0] div_quick_res;

  // Divide-by-zero and signed overflow have fixed answers, so they bypass the iteration.
  assign div_quick     = (b == '0) | (~funct3[0] & (a == XLEN_MIN) & (b == '1));
  assign div_quick_res = (b == '0) ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : XLEN_MIN);
  assign needs_iter    = is_m & ~(funct3[2] & div_quick);
`else
  assign needs_iter    = is_m & ~funct3[2];
`endif

  // ---------------- iteration datapath ----------------
  // acc: product high half / partial remainder; lo: multiplier / dividend-then-quotient.
  logic [XLEN-1:0]   acc, lo, opnd;
  logic [2:0]        op_f3;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   acc_step, lo_step, m_res;
`ifdef ALU_MDU_DIV_EN
  logic              neg_r;
  logic [XLEN:0]     rem_shift;
`endif

  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    acc_step = mul_sum[XLEN:1];
    lo_step  = {mul_sum[0], lo[XLEN-1:1]};
    prod     = {acc_step, lo_step};
    if (neg_q) prod = -prod;
    m_res    = (op_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
    rem_shift = {acc, lo[XLEN-1]};
    if (op_f3[2]) begin
      if (rem_shift >= {1'b0, opnd}) begin
        acc_step = rem_shift[XLEN-1:0] - opnd;
        lo_step  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_step = rem_shift[XLEN-1:0];
        lo_step  = {lo[XLEN-2:0], 1'b0};
      end
      if (op_f3[1]) m_res = neg_r ? -acc_step : acc_step;
      else          m_res = neg_q ? -lo_step : lo_step;
    end
`endif
  end

  // NOTE: the iteration registers have no reset; every accept loads them before BUSY reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_f3 <= funct3;
      neg_q <= a_neg ^ b_neg;
      acc   <= '0;
      lo    <= funct3[2] ? a_mag : b_mag;
      opnd  <= funct3[2] ? b_mag : a_mag;
`ifdef ALU_MDU_DIV_EN
      neg_r <= a_neg;
`endif
    end else if (state == BUSY) begin
      acc <= acc_step;
      lo  <= lo_step;
    end
  end

  // ---------------- result / flags / iteration count ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (!is_m) begin
        result <= alu_res;
        flags  <= {flag_v, carry, flag_n, flag_z};
      end else if (funct3[2]) begin
`ifdef ALU_MDU_DIV_EN
        if (div_quick) begin
          result <= div_quick_res;
          flags  <= m_flags(div_quick_res);
        end
`else
        result <= '0;
        flags  <= 4'b0001;
`endif
      end
    end else if (state == BUSY) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST_ITER) begin
        result <= m_res;
        flags  <= m_flags(m_res);
      end
    end
  end

  // ---------------- control FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign accept = in_valid & in_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = needs_iter ? BUSY : DONE;
      end
      BUSY: if (cnt == LAST_ITER) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
